// File: rtl/parity_pkg.sv
// Shared definitions for the 512-bit column-parity scheme.
// Used by both the parity generator and the receive-side checker.
`timescale 1ns/1ps

package parity_pkg;

  // Default geometry of the protected datapath
  localparam int DEF_DATA_WIDTH = 512;
  localparam int DEF_LANE_WIDTH = 64;
  localparam int DEF_CNT_WIDTH  = 32;

  // Number of XOR lanes folded into one check word
  localparam int NUM_LANES = DEF_DATA_WIDTH / DEF_LANE_WIDTH;

  // Check word / syndrome at the default lane width
  typedef logic [DEF_LANE_WIDTH-1:0] syndrome_t;

  // Reference check-word computation at the default geometry
  function automatic syndrome_t calc_check(input logic [DEF_DATA_WIDTH-1:0] data);
    syndrome_t acc;
    acc = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      acc = acc ^ data[i*DEF_LANE_WIDTH +: DEF_LANE_WIDTH];
    end
    return acc;
  endfunction

endpackage

// File: rtl/parity_checker_if.sv
// Streaming bus of the parity checker: the input word with its check word,
// and the checked output word with error flag and syndrome.
// master = producer/consumer environment, slave = the checker.
`timescale 1ns/1ps

interface parity_checker_if
  import parity_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LANE_WIDTH = DEF_LANE_WIDTH
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic [LANE_WIDTH-1:0] in_check;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_err;
  logic [LANE_WIDTH-1:0] out_syndrome;

  modport master (
    output in_valid, in_data, in_check, out_ready,
    input  in_ready, out_valid, out_data, out_err, out_syndrome
  );

  modport slave (
    input  in_valid, in_data, in_check, out_ready,
    output in_ready, out_valid, out_data, out_err, out_syndrome
  );

endinterface

// File: rtl/parity_fold.sv
// Combinational XOR of NUM_LANES lanes of LANE_WIDTH bits into one
// LANE_WIDTH-bit check word (lane 0 occupies the least significant bits).
`timescale 1ns/1ps

module parity_fold #(
  parameter int LANE_WIDTH = 64,
  parameter int NUM_LANES  = 8
) (
  input  logic [LANE_WIDTH*NUM_LANES-1:0] data,
  output logic [LANE_WIDTH-1:0]           fold
);

  // XOR every lane into the accumulator
  always_comb begin
    fold = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      fold = fold ^ data[i*LANE_WIDTH +: LANE_WIDTH];
    end
  end

endmodule

// File: rtl/parity_checker.sv
// Receive-side column-parity checker. A three-stage enabled shift register:
// S1 captures the word, S2 holds the lane fold, S3 holds the syndrome and
// drives the output. The whole pipe freezes while the output is stalled, so
// latency is fixed and bubbles are kept. Running statistics count delivered
// words and errors and remember the first error syndrome since the last clear.
`timescale 1ns/1ps

module parity_checker
  import parity_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LANE_WIDTH = DEF_LANE_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  parity_checker_if.slave       bus,
  input  logic                  clr_stats,
  output logic [CNT_WIDTH-1:0]  frame_count,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic                  sticky_err,
  output logic [LANE_WIDTH-1:0] first_syndrome
);

  // DATA_WIDTH is expected to be a whole number of lanes
  localparam int LANES = DATA_WIDTH / LANE_WIDTH;

  // Pipeline stage registers
  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;
  logic [LANE_WIDTH-1:0] s1_check;

  logic                  s2_valid;
  logic [DATA_WIDTH-1:0] s2_data;
  logic [LANE_WIDTH-1:0] s2_check;
  logic [LANE_WIDTH-1:0] s2_fold;

  logic                  s3_valid;
  logic [DATA_WIDTH-1:0] s3_data;
  logic                  s3_err;
  logic [LANE_WIDTH-1:0] s3_syndrome;

  // Handshake and datapath helpers
  logic                  stall;
  logic                  advance;
  logic                  deliver;
  logic [LANE_WIDTH-1:0] s1_fold;
  logic [LANE_WIDTH-1:0] syndrome_next;

  // Statistics next-state values
  logic [CNT_WIDTH-1:0]  frame_next;
  logic [CNT_WIDTH-1:0]  err_next;
  logic                  sticky_next;
  logic [LANE_WIDTH-1:0] first_next;

  // A held output freezes every stage; in_ready follows combinationally
  assign stall   = s3_valid && !bus.out_ready;
  assign advance = !stall;
  assign deliver = s3_valid && bus.out_ready;

  assign bus.in_ready     = advance;
  assign bus.out_valid    = s3_valid;
  assign bus.out_data     = s3_data;
  assign bus.out_err      = s3_err;
  assign bus.out_syndrome = s3_syndrome;

  // Lane fold of the S1 word, registered into S2
  parity_fold #(
    .LANE_WIDTH(LANE_WIDTH),
    .NUM_LANES (LANES)
  ) u_fold (
    .data(s1_data),
    .fold(s1_fold)
  );

  // Syndrome is the recomputed check word against the received one
  assign syndrome_next = s2_fold ^ s2_check;

  // Valid bits shift together; reset drops every in-flight word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else if (advance) begin
      s1_valid <= bus.in_valid;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
    end
  end

  // Data, check word, fold and syndrome move one stage per advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_data     <= '0;
      s1_check    <= '0;
      s2_data     <= '0;
      s2_check    <= '0;
      s2_fold     <= '0;
      s3_data     <= '0;
      s3_err      <= 1'b0;
      s3_syndrome <= '0;
    end else if (advance) begin
      s1_data     <= bus.in_data;
      s1_check    <= bus.in_check;
      s2_data     <= s1_data;
      s2_check    <= s1_check;
      s2_fold     <= s1_fold;
      s3_data     <= s2_data;
      s3_err      <= |syndrome_next;
      s3_syndrome <= syndrome_next;
    end
  end

  // Clear applies first, then the delivery in the same cycle is counted
  always_comb begin
    frame_next  = frame_count;
    err_next    = err_count;
    sticky_next = sticky_err;
    first_next  = first_syndrome;
    if (clr_stats) begin
      frame_next  = '0;
      err_next    = '0;
      sticky_next = 1'b0;
      first_next  = '0;
    end
    if (deliver) begin
      if (frame_next != '1) begin
        frame_next = frame_next + 1'b1;
      end
      if (s3_err) begin
        if (err_next != '1) begin
          err_next = err_next + 1'b1;
        end
        if (!sticky_next) begin
          sticky_next = 1'b1;
          first_next  = s3_syndrome;
        end
      end
    end
  end

  // Statistics registers visible to software
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_count    <= '0;
      err_count      <= '0;
      sticky_err     <= 1'b0;
      first_syndrome <= '0;
    end else begin
      frame_count    <= frame_next;
      err_count      <= err_next;
      sticky_err     <= sticky_next;
      first_syndrome <= first_next;
    end
  end

endmodule
